// File: rtl/hybrid_adder_if.sv
// Operand/result bundle for hybrid_adder.
//   a, b    : unsigned operands (WIDTH bits)
//   cy_in   : carry into bit 0
//   sum     : registered (a + b + cy_in) mod 2^WIDTH
//   cy_out  : registered carry out of bit WIDTH-1
// The master drives the operands and the slave (the adder) returns the result.
interface hybrid_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cy_in;
    logic [WIDTH-1:0] sum;
    logic             cy_out;

    modport master (
        output a,
        output b,
        output cy_in,
        input  sum,
        input  cy_out
    );

    modport slave (
        input  a,
        input  b,
        input  cy_in,
        output sum,
        output cy_out
    );
endinterface

// File: rtl/hybrid_adder.sv
// Hybrid adder with a registered result: {cy_out, sum} <= a + b + cy_in.
// The datapath is built from BLK-bit carry-lookahead blocks. Inside a block every
// carry is a flat two-level sum of products from the block carry-in; the
// carry-out of each block ripples into the next one.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high; clears sum and cy_out
//   bus  : hybrid_adder_if slave (a, b, cy_in in; sum, cy_out out)
// WIDTH must be a multiple of BLK and must match the interface WIDTH.
module hybrid_adder #(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    hybrid_adder_if.slave        bus
);
    localparam int NBLK = WIDTH / BLK;

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] sum_comb;
    logic [NBLK:0]    blk_cy;

    // Lookahead carries for one block. Entry 0 is the block carry-in, entry
    // i+1 the carry into bit i+1. Each carry is expanded as
    //   g_i | p_i g_(i-1) | p_i p_(i-1) g_(i-2) | ... | p_i..p_0 cin
    // so no carry depends on another carry inside the block.
    function automatic logic [BLK:0] cla_carry(
        input logic [BLK-1:0] g_in,
        input logic [BLK-1:0] p_in,
        input logic           cin
    );
        logic [BLK:0] c;
        logic         acc;
        logic         prod;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            acc  = g_in[i];
            prod = p_in[i];
            for (int k = i - 1; k >= 0; k--) begin
                acc  = acc | (prod & g_in[k]);
                prod = prod & p_in[k];
            end
            c[i+1] = acc | (prod & cin);
        end
        return c;
    endfunction

    assign gen       = bus.a & bus.b;
    assign prop      = bus.a ^ bus.b;
    assign blk_cy[0] = bus.cy_in;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [BLK:0] c;

        assign c = cla_carry(gen[k*BLK +: BLK], prop[k*BLK +: BLK], blk_cy[k]);
        assign sum_comb[k*BLK +: BLK] = prop[k*BLK +: BLK] ^ c[BLK-1:0];
        // Ripple between blocks.
        assign blk_cy[k+1] = c[BLK];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum    <= '0;
            bus.cy_out <= 1'b0;
        end else begin
            bus.sum    <= sum_comb;
            bus.cy_out <= blk_cy[NBLK];
        end
    end
endmodule

// File: tb/tb_hybrid_adder.sv
module tb_hybrid_adder;
    logic clk;
    logic rst;

    hybrid_adder_if #(.WIDTH(8)) bus ();

    hybrid_adder #(.WIDTH(8), .BLK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] exp_q [$];
    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    // Stimulus is applied on the falling edge; the expected {cy_out,sum} for the
    // rising edge that captures it is queued right after that edge.
    task automatic drive(input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic ci_v, input logic rst_v,
                         input logic [8:0] exp_v);
        @(negedge clk);
        bus.a     = a_v;
        bus.b     = b_v;
        bus.cy_in = ci_v;
        rst       = rst_v;
        @(posedge clk);
        exp_q.push_back(exp_v);
    endtask

    // Monitor: every edge that has a queued expectation is checked 2 time
    // units later, so results must appear exactly one edge after sampling.
    initial begin
        logic [8:0] exp_v;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                checks++;
                if ({bus.cy_out, bus.sum} !== exp_v) begin
                    failures++;
                    $display("FAIL result: got cy_out=%b sum=%h, want cy_out=%b sum=%h",
                             bus.cy_out, bus.sum, exp_v[8], exp_v[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [8:0] exp;
    } vec_t;

    vec_t dir_vecs [$];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] model;

        rst       = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cy_in = 1'b0;

        // Reset with non-zero operands present must still give zero.
        drive(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h000);
        drive(8'h6E, 8'hE6, 1'b1, 1'b1, 9'h000);

        dir_vecs = '{
            '{8'h6E, 8'hE6, 1'b1, 9'h155},
            '{8'hFF, 8'h00, 1'b1, 9'h100},
            '{8'h0F, 8'h01, 1'b0, 9'h010},
            '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
            '{8'h00, 8'h00, 1'b0, 9'h000},
            '{8'h00, 8'h00, 1'b1, 9'h001},
            '{8'h55, 8'hAA, 1'b1, 9'h100},
            '{8'h0F, 8'h00, 1'b1, 9'h010},
            '{8'h80, 8'h80, 1'b0, 9'h100},
            '{8'h12, 8'h34, 1'b0, 9'h046},
            '{8'hA5, 8'h5A, 1'b0, 9'h0FF},
            '{8'h07, 8'h09, 1'b1, 9'h011}
        };
        foreach (dir_vecs[i])
            drive(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].ci, 1'b0, dir_vecs[i].exp);

        // Back-to-back stream with a reset in the middle: the reset edges
        // discard the operands in flight, and the first operand after
        // deassert shows up one edge later.
        drive(8'h21, 8'h43, 1'b0, 1'b0, 9'h064);
        drive(8'hF0, 8'h10, 1'b1, 1'b0, 9'h101);
        drive(8'h7F, 8'h01, 1'b0, 1'b1, 9'h000);
        drive(8'hFF, 8'h01, 1'b1, 1'b1, 9'h000);
        drive(8'h3C, 8'hC3, 1'b1, 1'b0, 9'h100);
        drive(8'h01, 8'h02, 1'b0, 1'b0, 9'h003);

        // Random sweep against the arithmetic reference.
        for (int n = 0; n < 3000; n++) begin
            ra    = 8'($urandom_range(255));
            rb    = 8'($urandom_range(255));
            rc    = 1'($urandom_range(1));
            model = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            drive(ra, rb, rc, 1'b0, model);
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        done = 1;
        $finish;
    end
endmodule
